// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the IF/ID decoupling buffer: default widths, the bubble word
// and the derived pointer and count widths.
package if_id_buffer_pkg;

  localparam int BIT_NUMBER_DEF = 32;
  localparam int DEPTH_DEF      = 4;
  localparam int PTR_W_DEF      = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF      = $clog2(DEPTH_DEF + 1);

  // An all-zero word is what decode sees whenever no entry is valid.
  localparam logic [31:0] NOP = 32'h0;

endpackage

// File: rtl/if_id_buffer_mem.sv
// Entry storage for if_id_buffer: one synchronous write port and one asynchronous read port.
// The data array has no reset. The top module gates the read data with out_valid.
module if_id_buffer_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] entries [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries[wr_addr] <= wr_data;
    end
  end

  assign rd_data = entries[rd_addr];

endmodule

// File: rtl/if_id_buffer.sv
// FIFO between fetch and decode that holds {pc, instruction} pairs and freezes fetch when full.
// Define IF_ID_BUFFER_BYPASS_EN to forward a word straight to decode when the buffer is empty.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int BIT_NUMBER = BIT_NUMBER_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [BIT_NUMBER-1:0]        in_pc,
  input  logic [BIT_NUMBER-1:0]        in_instruction,
  output logic                         if_freeze,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIT_NUMBER-1:0]        out_pc,
  output logic [BIT_NUMBER-1:0]        out_instruction,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [BIT_NUMBER-1:0] BUBBLE     = BIT_NUMBER'(NOP);

  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [2*BIT_NUMBER-1:0] head_data;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign if_freeze = full;

`ifdef IF_ID_BUFFER_BYPASS_EN
  logic bypass;

  // An incoming word is forwarded when nothing is stored ahead of it. It is only
  // written into storage if decode does not take it in the same cycle.
  assign bypass    = empty & in_valid & ~flush;
  assign out_valid = ~empty | bypass;
  assign pop       = ~empty & out_ready & ~flush;
  assign push      = in_valid & ~full & ~flush & ~(bypass & out_ready);

  always_comb begin
    out_pc          = BUBBLE;
    out_instruction = BUBBLE;
    if (!empty) begin
      out_pc          = head_data[2*BIT_NUMBER-1:BIT_NUMBER];
      out_instruction = head_data[BIT_NUMBER-1:0];
    end else if (bypass) begin
      out_pc          = in_pc;
      out_instruction = in_instruction;
    end
  end
`else
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready & ~flush;
  assign push      = in_valid & ~full & ~flush;

  always_comb begin
    out_pc          = BUBBLE;
    out_instruction = BUBBLE;
    if (out_valid) begin
      out_pc          = head_data[2*BIT_NUMBER-1:BIT_NUMBER];
      out_instruction = head_data[BIT_NUMBER-1:0];
    end
  end
`endif

  // Flush overrides any push or pop in the same cycle. Both pointers return to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  if_id_buffer_mem #(
    .WIDTH(2 * BIT_NUMBER),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push),
    .wr_addr(wr_ptr),
    .wr_data({in_pc, in_instruction}),
    .rd_addr(rd_ptr),
    .rd_data(head_data)
  );

endmodule
